sdc_mport_arb: RTL and testbench
================================

Name: sdc_mport_arb

Overview:
- Parametrised N-port host front-end for the SDR/DDR-SDRAM controller.
- Arbitrates host requests (round-robin or fixed priority) and drives the controller's single host interface: sdr_req/ack, address, length, write data and mask.
- Routes wr_next and rd_valid beats back to the owning port.
- Exactly one transaction outstanding; a beat counter and a watchdog track completion.

Parameters:
- NPORT, 4, number of host ports (2..8).
- ADDR_W, 22, host address width; matches the controller's sdr_req_adr.
- DATA_W, 32, host data width.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 highest.
- TIMEOUT, 255, maximum idle cycles between beats in XFER before abort (8-bit counter).

Ports:
- mclk  in  1  master clock; single clock domain.
- s_reset  in  1  synchronous, active-high reset.
- p_req  in  NPORT  per-port request; held until p_ack.
- p_adr  in  NPORT*ADDR_W  per-port address, port i at slice [i*ADDR_W +: ADDR_W].
- p_len  in  NPORT*2  per-port burst length code.
- p_wr_n  in  NPORT  per-port direction: 0 = write, 1 = read.
- p_wr_data  in  NPORT*DATA_W  per-port write data.
- p_wr_en_n  in  NPORT*4  per-port byte mask, active-low.
- p_ack  out  NPORT  per-port request acknowledge.
- p_wr_next  out  NPORT  per-port write-data advance strobe.
- p_rd_valid  out  NPORT  per-port read-data valid.
- p_rd_data  out  DATA_W  read data, broadcast to all ports.
- sdr_req  out  1  request to controller.
- sdr_req_adr  out  ADDR_W  address to controller.
- sdr_req_len  out  2  length code to controller.
- sdr_req_wr_n  out  1  direction to controller.
- sdr_wr_data  out  DATA_W  write data to controller.
- sdr_wr_en_n  out  4  byte mask to controller.
- sdr_req_ack  in  1  controller acknowledge.
- sdr_wr_next  in  1  controller write-beat strobe.
- sdr_rd_valid  in  1  controller read-beat valid.
- sdr_rd_data  in  DATA_W  controller read data.
- sdr_init_done  in  1  controller initialisation complete.
- grant_id  out  3  index of the current owner port.
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky watchdog-abort flag.

Behaviour:
- Reset values:
  - state = IDLE; sdr_req = 0; sdr_req_adr = 0; sdr_req_len = 0; sdr_req_wr_n = 1.
  - grant_id = 0; busy = 0; err_timeout = 0; all p_* outputs = 0.
  - RR pointer = NPORT-1, so port 0 wins first.
- Burst length code: beats = 1 << len, i.e. 0→1, 1→2, 2→4, 3→8. The beat counter is 4 bits and loads the beat count.
- State IDLE:
  - Stays in IDLE while sdr_init_done = 0, regardless of p_req.
  - Otherwise, if p_req is non-zero, select winner g:
    - RR mode: first set bit searching from pointer+1, wrapping modulo NPORT.
    - Fixed mode: lowest set index.
  - Register grant_id = g and latch g's adr/len/wr_n into the sdr_req_* registers. Next cycle: sdr_req = 1, state → REQ.
  - Latency: p_req rising to sdr_req high = 1 cycle.
- State REQ:
  - sdr_req and all request fields stay stable until sdr_req_ack.
  - p_ack[g] = sdr_req_ack (combinational, same cycle).
  - On ack: sdr_req = 0 next cycle, load the beat counter, state → XFER, RR pointer = g.
  - If the port drops p_req while in REQ, the transaction still completes. This is a port protocol violation and is not recovered.
- State XFER:
  - Write (sdr_req_wr_n = 0):
    - sdr_wr_data and sdr_wr_en_n are combinational muxes of port g's inputs.
    - p_wr_next[g] = sdr_wr_next.
    - Each sdr_wr_next decrements the counter.
  - Read (sdr_req_wr_n = 1):
    - p_rd_valid[g] = sdr_rd_valid; p_rd_data = sdr_rd_data.
    - Each sdr_rd_valid decrements the counter.
  - A beat that arrives while counter = 1 → IDLE next cycle. There is a one-cycle bubble before the next grant.
  - Watchdog:
    - Counts cycles without a beat and clears on every beat.
    - On reaching TIMEOUT: err_timeout = 1 (cleared only by reset), state → IDLE.
- Ignored events:
  - sdr_rd_valid or sdr_wr_next outside XFER, or strobes of the wrong direction, are ignored.
  - All p_wr_next and p_rd_valid stay 0 outside XFER.
- sdr_wr_data and sdr_wr_en_n show port grant_id's inputs at all times; sdr_wr_en_n = 4'hF outside XFER.
- Simultaneous requests in RR mode: grants rotate strictly. With all ports requesting continuously, the order is 0, 1, 2, 3, 0, …
- Reset mid-transaction: on the cycle after s_reset, sdr_req = 0 and all outputs return to reset values; the burst in flight is abandoned.

Decomposition:
- Shared package sdc_pkg holds:
  - the state encoding: IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2;
  - the length decode function len2beats;
  - the PRIO_RR and PRIO_FIXED constants.
- One sub-module, sdc_rr_pick: a combinational NPORT-wide rotating priority encoder taking the request vector, pointer and mode, and returning winner index and valid.

Test Plan:
- Reset then init gating: s_reset for 2 cycles with p_req = 4'b0001 and sdr_init_done = 0 → sdr_req stays 0 and busy = 0. Raise init_done → sdr_req = 1 one cycle later, sdr_req_adr = p_adr[0], grant_id = 0.
- RR fairness: p_req = 4'hF held, ack after 3 cycles, len = 0, each burst ended by 1 beat → grant sequence 0, 1, 2, 3, 0. Each p_ack is exactly one cycle and only on the granted bit.
- Fixed priority: PRIO_MODE = 1, p_req = 4'b1010 → port 1 is granted repeatedly and port 3 is never granted while port 1 requests.
- Write burst: port 2, len = 2, data words A0..A3 → exactly 4 p_wr_next[2] pulses mirroring sdr_wr_next. sdr_wr_data equals port 2 data each beat. IDLE follows the cycle after the 4th beat.
- Read burst: port 1, len = 3 → 8 sdr_rd_valid beats appear only on p_rd_valid[1] with p_rd_data = sdr_rd_data. A stray rd_valid afterwards is not forwarded.
- Watchdog and reset: TIMEOUT = 16, write len = 1 with a single beat then silence → after 16 idle cycles err_timeout = 1 and state = IDLE. A separate run asserts s_reset while in XFER → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/sdc_mport_arb_pkg.sv
// Shared definitions for the multi-port SDRAM host arbiter: state encoding,
// arbitration mode constants and the burst-length decode.
package sdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Length code n means 2**n beats (1, 2, 4 or 8).
  function automatic logic [3:0] len2beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/sdc_rr_pick.sv
// Rotating priority encoder: picks the first requester after ptr (round-robin)
// or the lowest-indexed requester (fixed priority).
module sdc_rr_pick #(
  parameter int NPORT = 4
) (
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       ptr,
  input  logic             fixed,
  output logic [2:0]       win,
  output logic             vld
);

  logic [2*NPORT-1:0] dbl;
  logic [NPORT-1:0]   rot;
  logic [2:0]         base;
  logic [3:0]         sum;

  always_comb begin
    win  = '0;
    vld  = 1'b0;
    sum  = '0;
    base = fixed ? 3'd0 : ((ptr == 3'(NPORT-1)) ? 3'd0 : ptr + 3'd1);
    // Rotate so the search always starts at bit 0, then map back modulo NPORT.
    dbl  = {req, req} >> base;
    rot  = dbl[NPORT-1:0];
    for (int i = 0; i < NPORT; i++) begin
      if (!vld && rot[i]) begin
        vld = 1'b1;
        sum = 4'(base) + 4'(i);
        if (sum >= 4'(NPORT)) sum = sum - 4'(NPORT);
        win = sum[2:0];
      end
    end
  end

endmodule

// File: rtl/sdc_mport_arb.sv
// N-port host front-end for the SDRAM controller: arbitrates port requests,
// drives the single controller host interface and routes data beats back.
module sdc_mport_arb
  import sdc_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                    mclk,
  input  logic                    s_reset,
  input  logic [NPORT-1:0]        p_req,
  input  logic [NPORT*ADDR_W-1:0] p_adr,
  input  logic [NPORT*2-1:0]      p_len,
  input  logic [NPORT-1:0]        p_wr_n,
  input  logic [NPORT*DATA_W-1:0] p_wr_data,
  input  logic [NPORT*4-1:0]      p_wr_en_n,
  output logic [NPORT-1:0]        p_ack,
  output logic [NPORT-1:0]        p_wr_next,
  output logic [NPORT-1:0]        p_rd_valid,
  output logic [DATA_W-1:0]       p_rd_data,
  output logic                    sdr_req,
  output logic [ADDR_W-1:0]       sdr_req_adr,
  output logic [1:0]              sdr_req_len,
  output logic                    sdr_req_wr_n,
  output logic [DATA_W-1:0]       sdr_wr_data,
  output logic [3:0]              sdr_wr_en_n,
  input  logic                    sdr_req_ack,
  input  logic                    sdr_wr_next,
  input  logic                    sdr_rd_valid,
  input  logic [DATA_W-1:0]       sdr_rd_data,
  input  logic                    sdr_init_done,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam logic FIXED_MODE = (PRIO_MODE == PRIO_FIXED);

  state_e           state;
  logic [2:0]       rr_ptr;
  logic [3:0]       beat_cnt;
  logic [7:0]       wdog;
  logic [2:0]       pick_win;
  logic             pick_vld;
  logic             beat;
  logic [NPORT-1:0] gnt_oh;

  sdc_rr_pick #(.NPORT(NPORT)) u_pick (
    .req   (p_req),
    .ptr   (rr_ptr),
    .fixed (FIXED_MODE),
    .win   (pick_win),
    .vld   (pick_vld)
  );

  // Only strobes matching the latched direction count as beats.
  assign beat   = (state == XFER) && (sdr_req_wr_n ? sdr_rd_valid : sdr_wr_next);
  assign gnt_oh = NPORT'(1) << grant_id;
  assign busy   = (state != IDLE);

  assign p_ack       = (state == REQ && sdr_req_ack) ? gnt_oh : '0;
  assign p_wr_next   = (state == XFER && !sdr_req_wr_n && sdr_wr_next) ? gnt_oh : '0;
  assign p_rd_valid  = (state == XFER && sdr_req_wr_n && sdr_rd_valid) ? gnt_oh : '0;
  assign p_rd_data   = (state == XFER && sdr_req_wr_n) ? sdr_rd_data : '0;
  assign sdr_wr_data = p_wr_data[int'(grant_id)*DATA_W +: DATA_W];
  assign sdr_wr_en_n = (state == XFER) ? p_wr_en_n[int'(grant_id)*4 +: 4] : 4'hF;

  always_ff @(posedge mclk) begin
    if (s_reset) begin
      state        <= IDLE;
      sdr_req      <= 1'b0;
      sdr_req_adr  <= '0;
      sdr_req_len  <= '0;
      sdr_req_wr_n <= 1'b1;
      grant_id     <= '0;
      err_timeout  <= 1'b0;
      rr_ptr       <= 3'(NPORT-1);
      beat_cnt     <= '0;
      wdog         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sdr_init_done && pick_vld) begin
            grant_id     <= pick_win;
            sdr_req_adr  <= p_adr[int'(pick_win)*ADDR_W +: ADDR_W];
            sdr_req_len  <= p_len[int'(pick_win)*2 +: 2];
            sdr_req_wr_n <= p_wr_n[int'(pick_win) +: 1];
            sdr_req      <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (sdr_req_ack) begin
            sdr_req  <= 1'b0;
            beat_cnt <= len2beats(sdr_req_len);
            wdog     <= '0;
            rr_ptr   <= grant_id;
            state    <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            wdog     <= '0;
            beat_cnt <= beat_cnt - 4'd1;
            if (beat_cnt == 4'd1) state <= IDLE;
          end else if (wdog == 8'(TIMEOUT-1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_mport_arb.sv
// Bench for sdc_mport_arb: a round-robin instance and a fixed-priority
// instance, driven by directed and randomized transactions.
module tb_sdc_mport_arb;
  localparam int NP = 4, AW = 22, DW = 32, TO = 16;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic              s_reset, sdr_init_done;
  logic [NP-1:0]     p_req, p_wr_n;
  logic [NP*AW-1:0]  p_adr;
  logic [NP*2-1:0]   p_len;
  logic [NP*DW-1:0]  p_wr_data;
  logic [NP*4-1:0]   p_wr_en_n;
  logic              sdr_req_ack, sdr_wr_next, sdr_rd_valid;
  logic [DW-1:0]     sdr_rd_data;
  logic [NP-1:0]     p_ack, p_wr_next, p_rd_valid;
  logic [DW-1:0]     p_rd_data, sdr_wr_data;
  logic              sdr_req, sdr_req_wr_n, busy, err_timeout;
  logic [AW-1:0]     sdr_req_adr;
  logic [1:0]        sdr_req_len;
  logic [3:0]        sdr_wr_en_n;
  logic [2:0]        grant_id;

  logic              ack_f, wnx_f, rdv_f;
  logic [NP-1:0]     p_ack_f, p_wr_next_f, p_rd_valid_f;
  logic [DW-1:0]     p_rd_data_f, sdr_wr_data_f;
  logic              sdr_req_f, sdr_req_wr_n_f, busy_f, err_timeout_f;
  logic [AW-1:0]     sdr_req_adr_f;
  logic [1:0]        sdr_req_len_f;
  logic [3:0]        sdr_wr_en_n_f;
  logic [2:0]        grant_id_f;

  sdc_mport_arb #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TO)) dut (
    .mclk(mclk), .s_reset(s_reset), .p_req(p_req), .p_adr(p_adr), .p_len(p_len),
    .p_wr_n(p_wr_n), .p_wr_data(p_wr_data), .p_wr_en_n(p_wr_en_n), .p_ack(p_ack),
    .p_wr_next(p_wr_next), .p_rd_valid(p_rd_valid), .p_rd_data(p_rd_data),
    .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
    .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
    .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  sdc_mport_arb #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(TO)) dut_fx (
    .mclk(mclk), .s_reset(s_reset), .p_req(p_req), .p_adr(p_adr), .p_len(p_len),
    .p_wr_n(p_wr_n), .p_wr_data(p_wr_data), .p_wr_en_n(p_wr_en_n), .p_ack(p_ack_f),
    .p_wr_next(p_wr_next_f), .p_rd_valid(p_rd_valid_f), .p_rd_data(p_rd_data_f),
    .sdr_req(sdr_req_f), .sdr_req_adr(sdr_req_adr_f), .sdr_req_len(sdr_req_len_f),
    .sdr_req_wr_n(sdr_req_wr_n_f), .sdr_wr_data(sdr_wr_data_f), .sdr_wr_en_n(sdr_wr_en_n_f),
    .sdr_req_ack(ack_f), .sdr_wr_next(wnx_f), .sdr_rd_valid(rdv_f),
    .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done), .grant_id(grant_id_f),
    .busy(busy_f), .err_timeout(err_timeout_f)
  );

  int total = 0;
  int bad   = 0;
  int rr_last = NP - 1;

  // Winner from the arbitration rules: next requester after the last owner,
  // or the lowest requesting index in fixed mode.
  function automatic int model_pick(input logic [NP-1:0] req, input int last, input bit fixed);
    int idx;
    for (int k = 0; k < NP; k++) begin
      idx = fixed ? k : (last + 1 + k) % NP;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [NP-1:0] onehot(input int g);
    logic [NP-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (sdr_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("req_seen", sdr_req, 1'b1);
  endtask

  task automatic randomize_ports();
    for (int i = 0; i < NP; i++) begin
      p_adr[i*AW +: AW]    = AW'($urandom);
      p_wr_data[i*DW +: DW] = $urandom;
      p_wr_en_n[i*4 +: 4]  = 4'($urandom);
    end
  endtask

  // Plays the controller for one full transaction on the round-robin DUT.
  task automatic serve(input bit chk_bubble);
    int g, n, nb, gap;
    logic [DW-1:0] rd;
    logic [NP-1:0] oh;
    wait_req(n);
    if (chk_bubble) chk("bubble", n, 1);
    g  = model_pick(p_req, rr_last, 1'b0);
    oh = onehot(g);
    chk("grant", grant_id, g);
    chk("adr", sdr_req_adr, p_adr[g*AW +: AW]);
    chk("len", sdr_req_len, p_len[g*2 +: 2]);
    chk("dir", sdr_req_wr_n, p_wr_n[g]);
    chk("busy_req", busy, 1'b1);
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      chk("ack_early", p_ack, '0);
      tick();
      chk("req_hold", sdr_req, 1'b1);
    end
    sdr_req_ack = 1'b1;
    #1;
    chk("p_ack", p_ack, oh);
    tick();
    sdr_req_ack = 1'b0;
    #1;
    chk("req_drop", sdr_req, 1'b0);
    chk("ack_pulse", p_ack, '0);
    rr_last = g;
    nb = 1 << p_len[g*2 +: 2];
    for (int b = 0; b < nb; b++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        if (p_wr_n[g]) sdr_wr_next = 1'b1;
        else sdr_rd_valid = 1'b1;
        #1;
        chk("wrong_dir_wn", p_wr_next, '0);
        chk("wrong_dir_rv", p_rd_valid, '0);
        tick();
        sdr_wr_next = 1'b0;
        sdr_rd_valid = 1'b0;
        chk("busy_gap", busy, 1'b1);
      end
      if (!p_wr_n[g]) begin
        p_wr_data[g*DW +: DW] = $urandom;
        sdr_wr_next = 1'b1;
        #1;
        chk("wr_next", p_wr_next, oh);
        chk("wr_data", sdr_wr_data, p_wr_data[g*DW +: DW]);
        chk("wr_en_n", sdr_wr_en_n, p_wr_en_n[g*4 +: 4]);
        chk("rd_valid_on_wr", p_rd_valid, '0);
      end else begin
        rd = $urandom;
        sdr_rd_data = rd;
        sdr_rd_valid = 1'b1;
        #1;
        chk("rd_valid", p_rd_valid, oh);
        chk("rd_data", p_rd_data, rd);
        chk("wr_next_on_rd", p_wr_next, '0);
      end
      tick();
      sdr_wr_next = 1'b0;
      sdr_rd_valid = 1'b0;
      if (b < nb - 1) chk("busy_beat", busy, 1'b1);
    end
    chk("idle_after", busy, 1'b0);
    chk("req_low", sdr_req, 1'b0);
  endtask

  // Single-beat write transaction on the fixed-priority DUT.
  task automatic serve_f();
    int n, g;
    n = 0;
    while (sdr_req_f !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("fx_req_seen", sdr_req_f, 1'b1);
    g = model_pick(p_req, 0, 1'b1);
    chk("fx_grant", grant_id_f, g);
    ack_f = 1'b1;
    #1;
    chk("fx_p_ack", p_ack_f, onehot(g));
    tick();
    ack_f = 1'b0;
    wnx_f = 1'b1;
    #1;
    chk("fx_wr_next", p_wr_next_f, onehot(g));
    chk("fx_wr_data", sdr_wr_data_f, p_wr_data[g*DW +: DW]);
    tick();
    wnx_f = 1'b0;
    chk("fx_idle", busy_f, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    s_reset = 1'b1; sdr_init_done = 1'b0; p_req = 4'b0001;
    p_len = '0; p_wr_n = '0;
    sdr_req_ack = 1'b0; sdr_wr_next = 1'b0; sdr_rd_valid = 1'b0; sdr_rd_data = '0;
    ack_f = 1'b0; wnx_f = 1'b0; rdv_f = 1'b0;
    randomize_ports();
    tick();
    tick();
    s_reset = 1'b0;
    #1;
    chk("rst_req", sdr_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_wr_n", sdr_req_wr_n, 1'b1);
    chk("rst_adr", sdr_req_adr, '0);
    chk("rst_en_n", sdr_wr_en_n, 4'hF);
    chk("rst_p_ack", p_ack, '0);

    repeat (3) begin
      tick();
      chk("init_gate_req", sdr_req, 1'b0);
      chk("init_gate_busy", busy, 1'b0);
    end
    sdr_init_done = 1'b1;
    tick();
    chk("init_latency", sdr_req, 1'b1);
    chk("init_grant", grant_id, 3'd0);
    chk("init_adr", sdr_req_adr, p_adr[0 +: AW]);
    serve(1'b0);

    // All ports requesting: strict rotation 1, 2, 3, 0, 1.
    p_req = 4'hF; p_len = '0; p_wr_n = NP'($urandom);
    repeat (5) serve(1'b1);

    repeat (12) begin
      p_req  = NP'($urandom_range(1, 15));
      p_len  = 8'($urandom);
      p_wr_n = NP'($urandom);
      randomize_ports();
      serve(1'b1);
    end

    p_req = 4'b0100; p_len[5:4] = 2'd2; p_wr_n[2] = 1'b0;
    serve(1'b1);

    p_req = 4'b0010; p_len[3:2] = 2'd3; p_wr_n[1] = 1'b1;
    serve(1'b1);
    p_req = '0;
    sdr_rd_data = 32'hDEAD_BEEF;
    sdr_rd_valid = 1'b1;
    #1;
    chk("stray_rd_valid", p_rd_valid, '0);
    chk("stray_rd_data", p_rd_data, '0);
    tick();
    sdr_rd_valid = 1'b0;
    chk("stray_busy", busy, 1'b0);

    // Watchdog: one beat of a two-beat write, then silence.
    p_req = 4'b0001; p_len[1:0] = 2'd1; p_wr_n[0] = 1'b0;
    wait_req(n);
    chk("wd_grant", grant_id, 3'd0);
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    p_req = '0;
    rr_last = 0;
    sdr_wr_next = 1'b1;
    tick();
    sdr_wr_next = 1'b0;
    repeat (TO - 1) tick();
    chk("wd_err_early", err_timeout, 1'b0);
    chk("wd_busy_early", busy, 1'b1);
    tick();
    chk("wd_err", err_timeout, 1'b1);
    chk("wd_idle", busy, 1'b0);
    tick();
    chk("wd_sticky", err_timeout, 1'b1);

    // Reset in the middle of a read burst.
    p_req = 4'b1000; p_len[7:6] = 2'd3; p_wr_n[3] = 1'b1;
    wait_req(n);
    chk("mid_grant", grant_id, 3'd3);
    sdr_req_ack = 1'b1;
    tick();
    sdr_req_ack = 1'b0;
    sdr_rd_valid = 1'b1;
    tick();
    sdr_rd_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    s_reset = 1'b1;
    tick();
    sdr_rd_valid = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req", sdr_req, 1'b0);
    chk("mid_rst_grant", grant_id, 3'd0);
    chk("mid_rst_err", err_timeout, 1'b0);
    chk("mid_rst_adr", sdr_req_adr, '0);
    chk("mid_rst_len", sdr_req_len, 2'd0);
    chk("mid_rst_wr_n", sdr_req_wr_n, 1'b1);
    chk("mid_rst_rd_valid", p_rd_valid, '0);
    chk("mid_rst_en_n", sdr_wr_en_n, 4'hF);
    sdr_rd_valid = 1'b0;
    rr_last = NP - 1;
    p_req = 4'hF; p_len = '0;
    s_reset = 1'b0;
    serve(1'b0);

    // Fixed priority instance: port 1 keeps beating port 3.
    s_reset = 1'b1;
    p_req = 4'b1010; p_len = '0; p_wr_n = '0;
    tick();
    tick();
    s_reset = 1'b0;
    repeat (3) serve_f();
    p_req = 4'b1000;
    serve_f();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
